// File: rtl/aes_fsm_pkg.sv
// Shared types and constants for the AES job sequencer.
package aes_package;

  localparam int unsigned AES_BLOCK_BITS = 128;
  localparam int unsigned AES_CNT_W      = 16;
  localparam int unsigned AES_PERF_W     = 32;

  typedef enum logic [2:0] {
    StIdle,
    StKey,
    StKexp,
    StFetch,
    StCrypt,
    StStore,
    StDone
  } aes_fsm_state_t;

endpackage

// File: rtl/aes_fsm_if.sv
// Start/done handshakes between the sequencer and the streamer/engine pair.
interface aes_fsm_if;

  logic key_start;
  logic key_done;
  logic eng_kexp;
  logic eng_kexp_done;
  logic src_start;
  logic src_done;
  logic eng_start;
  logic eng_done;
  logic sink_start;
  logic sink_done;

  modport master (
    output key_start, eng_kexp, src_start, eng_start, sink_start,
    input  key_done, eng_kexp_done, src_done, eng_done, sink_done
  );

  modport slave (
    input  key_start, eng_kexp, src_start, eng_start, sink_start,
    output key_done, eng_kexp_done, src_done, eng_done, sink_done
  );

endinterface

// File: rtl/aes_fsm.sv
// AES job sequencer: key load/expand once, then fetch/crypt/store per block, then done.
// Optional busy-cycle counter enabled by AES_FSM_PERF_CNT_EN.
module aes_fsm
  import aes_package::*;
#(
  parameter int unsigned CNT_W  = AES_CNT_W,
  parameter int unsigned PERF_W = AES_PERF_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_blocks_i,
  aes_fsm_if.master         hs_io,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  blk_cnt_o,
  output logic [PERF_W-1:0] perf_cnt_o
);

  aes_fsm_state_t   state_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] blk_cnt_q;
  logic [CNT_W-1:0] blk_inc;
  logic             key_start_q, kexp_q, src_start_q, eng_start_q, sink_start_q;
  logic             busy_q, done_q;

  assign blk_inc = blk_cnt_q + CNT_W'(1);

  // Each start pulse is raised on the edge that enters its state, so it covers
  // exactly the first cycle of that state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      n_q          <= '0;
      blk_cnt_q    <= '0;
      key_start_q  <= 1'b0;
      kexp_q       <= 1'b0;
      src_start_q  <= 1'b0;
      eng_start_q  <= 1'b0;
      sink_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      key_start_q  <= 1'b0;
      kexp_q       <= 1'b0;
      src_start_q  <= 1'b0;
      eng_start_q  <= 1'b0;
      sink_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (clear_i) begin
        state_q   <= StIdle;
        blk_cnt_q <= '0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              n_q       <= n_blocks_i;
              blk_cnt_q <= '0;
              busy_q    <= 1'b1;
              if (n_blocks_i == '0) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q     <= StKey;
                key_start_q <= 1'b1;
              end
            end
          end
          StKey: begin
            if (hs_io.key_done) begin
              state_q <= StKexp;
              kexp_q  <= 1'b1;
            end
          end
          StKexp: begin
            if (hs_io.eng_kexp_done) begin
              state_q     <= StFetch;
              src_start_q <= 1'b1;
            end
          end
          StFetch: begin
            if (hs_io.src_done) begin
              state_q     <= StCrypt;
              eng_start_q <= 1'b1;
            end
          end
          StCrypt: begin
            if (hs_io.eng_done) begin
              state_q      <= StStore;
              sink_start_q <= 1'b1;
            end
          end
          StStore: begin
            if (hs_io.sink_done) begin
              blk_cnt_q <= blk_inc;
              if (blk_inc == n_q) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q     <= StFetch;
                src_start_q <= 1'b1;
              end
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef AES_FSM_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (clear_i || (state_q == StIdle && start_i)) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign perf_cnt_o = perf_q;
`else
  assign perf_cnt_o = '0;
`endif

  assign hs_io.key_start  = key_start_q;
  assign hs_io.eng_kexp   = kexp_q;
  assign hs_io.src_start  = src_start_q;
  assign hs_io.eng_start  = eng_start_q;
  assign hs_io.sink_start = sink_start_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign blk_cnt_o        = blk_cnt_q;

endmodule

// File: tb/tb_aes_fsm.sv
// Self-checking bench for aes_fsm: job-level reference model plus directed and random jobs.
module tb_aes_fsm;
  import aes_package::*;

  localparam int unsigned CW = AES_CNT_W;
  localparam int unsigned PW = AES_PERF_W;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] n_blocks_i = '0;
  logic          busy_o, done_o;
  logic [CW-1:0] blk_cnt_o;
  logic [PW-1:0] perf_cnt_o;

  aes_fsm_if hs ();

  aes_fsm #(.CNT_W(CW), .PERF_W(PW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .n_blocks_i (n_blocks_i),
    .hs_io      (hs),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .blk_cnt_o  (blk_cnt_o),
    .perf_cnt_o (perf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Job model: a job is a list of steps (0 key, 1 kexp, 2 fetch, 3 crypt, 4 store, 5 done).
  bit      m_active, m_entered;
  int      m_steps[$];
  int      m_ptr;
  longint  m_blk, m_perf;
  int      pend[5];
  int      delay_mode = 1;
  bit      spur_en = 1'b0;
  int      c_pulse[5];
  int      c_done, c_busy;
  int      cyc = 0;
  int      last_done_cyc = -1;
  longint  perf_max = (64'd1 << PW) - 1;

  task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int m_kind();
    return m_active ? m_steps[m_ptr] : -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_entered = 0; m_blk = 0; m_perf = 0; m_ptr = 0;
    m_steps.delete();
    for (int k = 0; k < 5; k++) pend[k] = -1;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 5; k++) c_pulse[k] = 0;
    c_done = 0; c_busy = 0;
  endtask

  task automatic check_outputs();
    logic [4:0] got_p, exp_p;
    int k;
    k = m_kind();
    got_p = {hs.sink_start, hs.eng_start, hs.src_start, hs.eng_kexp, hs.key_start};
    exp_p = (m_active && m_entered && k < 5) ? 5'(1 << k) : 5'd0;
    expect_eq("pulses", 64'(got_p), 64'(exp_p));
    expect_eq("busy", 64'(busy_o), 64'(m_active));
    expect_eq("done", 64'(done_o), 64'(m_active && k == 5));
    expect_eq("blk_cnt", 64'(blk_cnt_o), 64'(m_blk));
`ifdef AES_FSM_PERF_CNT_EN
    expect_eq("perf_cnt", 64'(perf_cnt_o), 64'(m_perf));
`else
    expect_eq("perf_cnt", 64'(perf_cnt_o), 64'd0);
`endif
    for (int i = 0; i < 5; i++) if (got_p[i]) c_pulse[i]++;
    if (done_o) begin c_done++; last_done_cyc = cyc; end
    if (busy_o) c_busy++;
  endtask

  task automatic model_advance(input bit st, input int unsigned nb, input bit clr,
                               input logic [4:0] dn);
    int k;
    if (clr) begin
      model_reset();
    end else if (!m_active) begin
      if (st) begin
        m_blk = 0; m_perf = 0; m_ptr = 0;
        m_steps.delete();
        if (nb != 0) begin
          m_steps.push_back(0); m_steps.push_back(1);
          for (int b = 0; b < int'(nb); b++) begin
            m_steps.push_back(2); m_steps.push_back(3); m_steps.push_back(4);
          end
        end
        m_steps.push_back(5);
        m_active = 1; m_entered = 1;
      end
    end else begin
      if (m_perf != perf_max) m_perf++;
      k = m_kind();
      if (k == 5) begin
        m_active = 0; m_entered = 0;
      end else if (dn[k]) begin
        if (k == 4) m_blk++;
        m_ptr++; m_entered = 1;
      end else begin
        m_entered = 0;
      end
    end
  endtask

  // One clock: check the current cycle, then drive the inputs for the coming edge.
  task automatic cycle(input bit st, input int unsigned nb, input bit clr);
    logic [4:0] dn;
    int k;
    @(negedge clk_i);
    cyc++;
    check_outputs();
    k = m_kind();
    if (m_active && m_entered && k < 5)
      pend[k] = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
    for (int i = 0; i < 5; i++) begin
      dn[i] = (pend[i] == 0);
      if (pend[i] >= 0) pend[i]--;
      if (spur_en && i != k && $urandom_range(0, 7) == 0) dn[i] = 1'b1;
    end
    start_i = st; n_blocks_i = CW'(nb); clear_i = clr;
    hs.key_done = dn[0]; hs.eng_kexp_done = dn[1]; hs.src_done = dn[2];
    hs.eng_done = dn[3]; hs.sink_done = dn[4];
    model_advance(st, nb, clr, dn);
  endtask

  task automatic finish_job(input bit noise, input int clr_rate);
    int i;
    for (i = 0; i < 3000 && m_active; i++) begin
      cycle(noise ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 7),
            (clr_rate > 0) ? ($urandom_range(0, clr_rate - 1) == 0) : 1'b0);
    end
    if (m_active) begin
      checks++; errors++;
      $display("FAIL job_timeout got busy expected idle (cycle %0d)", cyc);
      model_reset();
    end
    cycle(0, 0, 0);
  endtask

  initial begin
    int s;
    model_reset();
    clear_counts();
    hs.key_done = 0; hs.eng_kexp_done = 0; hs.src_done = 0; hs.eng_done = 0; hs.sink_done = 0;
    #2;
    expect_eq("rst_busy", 64'(busy_o), 64'd0);
    expect_eq("rst_done", 64'(done_o), 64'd0);
    expect_eq("rst_blk", 64'(blk_cnt_o), 64'd0);
    expect_eq("rst_pulse", 64'({hs.key_start, hs.eng_kexp, hs.src_start, hs.eng_start,
                                hs.sink_start}), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(0, 0, 0);

    // n=3, every done one cycle after its start
    clear_counts();
    delay_mode = 1;
    cycle(1, 3, 0);
    finish_job(0, 0);
    expect_eq("n3_key", 64'(c_pulse[0]), 64'd1);
    expect_eq("n3_kexp", 64'(c_pulse[1]), 64'd1);
    expect_eq("n3_src", 64'(c_pulse[2]), 64'd3);
    expect_eq("n3_eng", 64'(c_pulse[3]), 64'd3);
    expect_eq("n3_sink", 64'(c_pulse[4]), 64'd3);
    expect_eq("n3_done", 64'(c_done), 64'd1);
    expect_eq("n3_busy_cycles", 64'(c_busy), 64'd23);
    expect_eq("n3_blk_end", 64'(blk_cnt_o), 64'd3);
    expect_eq("n3_busy_end", 64'(busy_o), 64'd0);
`ifdef AES_FSM_PERF_CNT_EN
    expect_eq("n3_perf_hold", 64'(perf_cnt_o), 64'd23);
`endif

    // n=0: straight to done
    clear_counts();
    s = cyc + 1;
    cycle(1, 0, 0);
    finish_job(0, 0);
    expect_eq("n0_pulses", 64'(c_pulse[0] + c_pulse[1] + c_pulse[2] + c_pulse[3] + c_pulse[4]),
              64'd0);
    expect_eq("n0_done_lat", 64'(last_done_cyc - s), 64'd1);
    expect_eq("n0_blk", 64'(blk_cnt_o), 64'd0);

    // n=2 with start_i hammered throughout the job
    clear_counts();
    cycle(1, 2, 0);
    finish_job(1, 0);
    expect_eq("n2_noise_blk", 64'(blk_cnt_o), 64'd2);
    expect_eq("n2_noise_done", 64'(c_done), 64'd1);

    // clear during the store of the second block of an n=4 job
    clear_counts();
    cycle(1, 4, 0);
    for (int i = 0; i < 100 && !(m_kind() == 4 && m_blk == 1); i++) cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    expect_eq("clr_busy", 64'(busy_o), 64'd0);
    expect_eq("clr_blk", 64'(blk_cnt_o), 64'd0);
    expect_eq("clr_no_done", 64'(c_done), 64'd0);
    clear_counts();
    cycle(1, 1, 0);
    finish_job(0, 0);
    expect_eq("after_clr_blk", 64'(blk_cnt_o), 64'd1);
    expect_eq("after_clr_done", 64'(c_done), 64'd1);

    // random jobs: random latencies, stray dones, start noise, occasional clear
    delay_mode = -1;
    spur_en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      cycle(1, $urandom_range(0, 5), 0);
      finish_job(1'($urandom_range(0, 1)), 48);
    end
    spur_en = 1'b0;
    delay_mode = 1;

    // asynchronous reset while in FETCH
    cycle(1, 2, 0);
    for (int i = 0; i < 100 && m_kind() != 2; i++) cycle(0, 0, 0);
    @(posedge clk_i);
    #3;
    expect_eq("pre_rst_src", 64'(hs.src_start), 64'd1);
    rst_ni = 1'b0;
    #1;
    expect_eq("arst_pulse", 64'({hs.key_start, hs.eng_kexp, hs.src_start, hs.eng_start,
                                 hs.sink_start}), 64'd0);
    expect_eq("arst_busy", 64'(busy_o), 64'd0);
    expect_eq("arst_done", 64'(done_o), 64'd0);
    expect_eq("arst_blk", 64'(blk_cnt_o), 64'd0);
    expect_eq("arst_perf", 64'(perf_cnt_o), 64'd0);
    @(negedge clk_i);
    start_i = 0; clear_i = 0;
    hs.key_done = 0; hs.eng_kexp_done = 0; hs.src_done = 0; hs.eng_done = 0; hs.sink_done = 0;
    model_reset();
    rst_ni = 1'b1;
    cycle(1, 1, 0);
    finish_job(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
